dot_mac_sequencer: RTL and testbench

//  Control FSM for the AXIS matrix-vector dot engine (ROWS-element input vector, COLS outputs).

---
 rtl/dot_pkg.sv | 20 ++
 rtl/dot_valid_pipe.sv | 28 ++
 rtl/dot_mac_sequencer.sv | 134 +++++++++++++
 tb/tb_dot_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared state type and default sizing for the dot-product MAC sequencer.
package dot_pkg;

  localparam int DEF_ROWS    = 80;
  localparam int DEF_COLS    = 40;
  localparam int DEF_RD_LAT  = 1;
  localparam int DEF_MAC_LAT = 4;  // MAC depth; the FSM waits on mac_out_valid and never counts this

  localparam int ROW_W = $clog2(DEF_ROWS);
  localparam int COL_W = $clog2(DEF_COLS);
  localparam int WGT_W = $clog2(DEF_ROWS * DEF_COLS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } dot_state_t;

endpackage

// File: rtl/dot_valid_pipe.sv
// Delays the {valid, first, last} issue flags by the RAM/ROM read latency.
module dot_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (RD_LAT == 0) begin : g_wire
    assign q = d;
  end else begin : g_reg
    logic [2:0] stage [RD_LAT];

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[RD_LAT-1];
  end

endmodule

// File: rtl/dot_mac_sequencer.sv
// Sequencer for the matrix-vector dot engine: loads the vector, walks the weights
// column-major into one shared MAC, and hands each column sum to the output stream.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_LOAD  | accept ROWS input beats into the vector RAM
//   S_ISSUE | issue ROWS back-to-back (row, weight) reads for one column
//   S_DRAIN | wait for the MAC to return the column sum
//   S_OUT   | present the sum on the output stream until accepted
module dot_mac_sequencer
  import dot_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int RD_LAT = DEF_RD_LAT,
  localparam int ROW_BITS = $clog2(ROWS),
  localparam int COL_BITS = $clog2(COLS),
  localparam int WGT_BITS = $clog2(ROWS * COLS)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                in_tvalid,
  input  logic                in_tlast,
  output logic                in_tready,
  output logic                vec_we,
  output logic [ROW_BITS-1:0] vec_waddr,
  output logic [ROW_BITS-1:0] vec_raddr,
  output logic [WGT_BITS-1:0] wgt_raddr,
  output logic                mac_in_valid,
  output logic                mac_in_first,
  output logic                mac_in_last,
  input  logic                mac_out_valid,
  output logic                out_load,
  output logic                out_tvalid,
  output logic                out_tlast,
  input  logic                out_tready,
  output logic                err
);

  dot_state_t          state;
  logic                active;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [WGT_BITS-1:0] wgt;
  logic                beat;
  logic                issue;
  logic                row_last;
  logic                col_last;
  logic [2:0]          pipe_q;

  assign row_last = (row == ROW_BITS'(ROWS - 1));
  assign col_last = (col == COL_BITS'(COLS - 1));

  // active keeps in_tready low while reset is held, even though state already reads S_LOAD
  assign in_tready = active && (state == S_LOAD);
  assign beat      = in_tvalid && in_tready;
  assign vec_we    = beat;
  assign vec_waddr = row;
  assign vec_raddr = row;
  assign wgt_raddr = wgt;
  assign issue     = (state == S_ISSUE);

  assign out_load   = (state == S_DRAIN) && mac_out_valid;
  assign out_tvalid = (state == S_OUT);
  assign out_tlast  = (state == S_OUT) && col_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= S_LOAD;
      active <= 1'b0;
      row    <= '0;
      col    <= '0;
      wgt    <= '0;
      err    <= 1'b0;
    end else begin
      active <= 1'b1;
      if ((beat && in_tlast && !row_last) || (mac_out_valid && state != S_DRAIN))
        err <= 1'b1;

      case (state)
        S_LOAD: begin
          if (beat) begin
            if (row_last) begin
              row   <= '0;
              col   <= '0;
              wgt   <= '0;
              state <= S_ISSUE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // wgt runs on across columns, so col*ROWS+row never needs a multiplier
          wgt <= wgt + 1'b1;
          if (row_last) begin
            row   <= '0;
            state <= S_DRAIN;
          end else begin
            row <= row + 1'b1;
          end
        end
        S_DRAIN: begin
          if (mac_out_valid) state <= S_OUT;
        end
        S_OUT: begin
          if (out_tready) begin
            if (col_last) begin
              state <= S_LOAD;
            end else begin
              col   <= col + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  dot_valid_pipe #(
    .RD_LAT(RD_LAT)
  ) u_valid_pipe (
    .aclk   (aclk),
    .aresetn(aresetn),
    .d      ({issue, issue && (row == '0), issue && row_last}),
    .q      (pipe_q)
  );

  assign mac_in_valid = pipe_q[2];
  assign mac_in_first = pipe_q[1];
  assign mac_in_last  = pipe_q[0];

endmodule

// File: tb/tb_dot_mac_sequencer.sv
// Bench for dot_mac_sequencer: behavioural vector RAM, weight ROM and integer MAC
// (RD_LAT=1, MAC_LAT=4); column sums are checked against a directly computed dot product.
module tb_dot_mac_sequencer;

  localparam int ROWS = 80;
  localparam int COLS = 40;

  logic        aclk;
  logic        aresetn;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic        vec_we;
  logic [6:0]  vec_waddr;
  logic [6:0]  vec_raddr;
  logic [11:0] wgt_raddr;
  logic        mac_in_valid;
  logic        mac_in_first;
  logic        mac_in_last;
  logic        mac_out_valid;
  logic        out_load;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready;
  logic        err;

  dot_mac_sequencer dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .in_tvalid    (in_tvalid),
    .in_tlast     (in_tlast),
    .in_tready    (in_tready),
    .vec_we       (vec_we),
    .vec_waddr    (vec_waddr),
    .vec_raddr    (vec_raddr),
    .wgt_raddr    (wgt_raddr),
    .mac_in_valid (mac_in_valid),
    .mac_in_first (mac_in_first),
    .mac_in_last  (mac_in_last),
    .mac_out_valid(mac_out_valid),
    .out_load     (out_load),
    .out_tvalid   (out_tvalid),
    .out_tlast    (out_tlast),
    .out_tready   (out_tready),
    .err          (err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- behavioural memories and MAC ----------------
  int unsigned vec_src [ROWS];
  int unsigned rom [4096];
  int unsigned ram [128];
  int unsigned tdata;
  int unsigned rd_v, rd_w, acc, out_data;
  int unsigned dly_d [4];
  logic [3:0]  dly_v;
  logic        inj;

  assign mac_out_valid = dly_v[3] | inj;

  always @(posedge aclk) begin
    int unsigned s;
    rd_v <= ram[vec_raddr];
    rd_w <= rom[wgt_raddr];
    if (vec_we) ram[vec_waddr] <= tdata;
    if (out_load) out_data <= dly_d[3];
    s = (mac_in_first ? 0 : acc) + rd_v * rd_w;
    if (!aresetn) begin
      dly_v <= '0;
    end else begin
      if (mac_in_valid) acc <= s;
      dly_v    <= {dly_v[2:0], mac_in_valid & mac_in_last};
      dly_d[0] <= s;
      for (int i = 1; i < 4; i++) dly_d[i] <= dly_d[i-1];
    end
  end

  function automatic int unsigned dot(input int c);
    int unsigned s;
    s = 0;
    for (int r = 0; r < ROWS; r++) s += vec_src[r] * rom[c * ROWS + r];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  int checks;
  int failures;
  logic [6:0]  prev_vec;
  logic [11:0] prev_wgt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    prev_vec = vec_raddr;
    prev_wgt = wgt_raddr;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [39:0] outs();
    return {5'd0, in_tready, vec_we, vec_waddr, vec_raddr, wgt_raddr, mac_in_valid,
            mac_in_first, mac_in_last, out_load, out_tvalid, out_tlast, err};
  endfunction

  // ---------------- scenario table ----------------
  typedef struct {
    int tlast_beat;  // beat carrying in_tlast
    int stall_col;   // output index held with out_tready=0 (-1: none)
    int stall_len;
    int inj_col;     // column in which a stray mac_out_valid is pulsed (-1: none)
    int reset_col;   // column in which reset is pulsed mid-issue (-1: none)
    bit rnd;         // random input gaps / random out_tready / stray in_tvalid
    bit exp_err;     // err expected at end of the scenario
  } scen_t;

  scen_t tbl [5];
  scen_t sc;
  bit    exp_err, aborted, stall_on;
  int    b, nbad, cyc, cyc_a, oidx, k, icol, stall_n, stall_bad;
  int unsigned last_wgt;

  initial begin
    checks    = 0;
    failures  = 0;
    aresetn   = 1'b0;
    in_tvalid = 1'b1;
    in_tlast  = 1'b0;
    out_tready = 1'b0;
    inj       = 1'b0;
    tdata     = 0;
    dly_v     = '0;
    acc       = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = $urandom_range(0, 255);

    tbl[0] = '{79, -1,  0, -1, -1, 1'b0, 1'b0};
    tbl[1] = '{79,  5, 10, -1, -1, 1'b0, 1'b0};
    tbl[2] = '{19, -1,  0,  3, -1, 1'b0, 1'b1};
    tbl[3] = '{79, -1,  0, -1, 12, 1'b0, 1'b0};
    tbl[4] = '{79, -1,  0, -1, -1, 1'b1, 1'b0};

    // reset held with in_tvalid asserted
    repeat (20) step();
    chk("rst_in_tready", in_tready, 0);
    chk("rst_outputs", outs(), 0);
    in_tvalid = 1'b0;
    aresetn   = 1'b1;
    step();
    chk("ready_after_rst", in_tready, 1);
    chk("err_after_rst", err, 0);

    for (int t = 0; t < 5; t++) begin
      sc = tbl[t];
      for (int r = 0; r < ROWS; r++) vec_src[r] = $urandom_range(0, 255);

      // load phase
      b = 0; nbad = 0; cyc_a = 0;
      while (b < ROWS && cyc_a < 2000) begin
        in_tvalid = sc.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_tlast  = (b == sc.tlast_beat);
        tdata     = vec_src[b];
        #1;
        if (in_tvalid) begin
          if (!(vec_we && in_tready && vec_waddr == 7'(b))) nbad++;
          if (in_tready) b++;
        end else if (vec_we) begin
          nbad++;
        end
        step();
        cyc_a++;
      end
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      if (sc.tlast_beat != ROWS - 1) exp_err = 1'b1;
      chk("load_beats", b, ROWS);
      chk("load_addr", nbad, 0);
      chk("err_after_load", err, exp_err);

      // compute / output phase
      oidx = 0; k = 0; icol = 0; nbad = 0; cyc = 0; aborted = 0;
      stall_on = 0; stall_n = 0; stall_bad = 0; last_wgt = 0;
      while (oidx < COLS && cyc < 20000 && !aborted) begin
        if (mac_in_valid) begin
          if (prev_vec != 7'(k) || prev_wgt != 12'(icol * ROWS + k) ||
              mac_in_first != (k == 0) || mac_in_last != (k == ROWS - 1) ||
              (k == 0 && icol != oidx)) nbad++;
          last_wgt = prev_wgt;
          k++;
          if (k == ROWS) begin
            k = 0;
            icol++;
          end
        end else if (k != 0 || mac_in_first || mac_in_last) begin
          nbad++;
        end
        if (out_tlast && !out_tvalid) nbad++;

        if (sc.reset_col >= 0 && icol == sc.reset_col && k == ROWS / 2) begin
          aresetn = 1'b0;
          step();
          chk("midrst_outputs", outs(), 0);
          aresetn = 1'b1;
          step();
          chk("midrst_ready", in_tready, 1);
          exp_err = 1'b0;
          aborted = 1'b1;
        end else begin
          in_tvalid = sc.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
          if (sc.inj_col >= 0 && icol == sc.inj_col && k == 10 && mac_in_valid) begin
            inj     = 1'b1;
            exp_err = 1'b1;
          end
          if (oidx == sc.stall_col && out_tvalid && stall_n == 0) stall_on = 1'b1;
          if (stall_on && stall_n < sc.stall_len) begin
            out_tready = 1'b0;
            stall_n++;
            if (!out_tvalid || out_tlast || mac_in_valid) stall_bad++;
          end else begin
            out_tready = sc.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          #1;
          if (in_tvalid && vec_we) nbad++;
          if (out_tvalid && out_tready) begin
            chk("out_data", out_data, dot(oidx));
            chk("out_tlast", out_tlast, oidx == COLS - 1);
            oidx++;
          end
          step();
          inj = 1'b0;
          cyc++;
        end
      end
      in_tvalid  = 1'b0;
      out_tready = 1'b0;

      chk("issue_seq", nbad, 0);
      chk("err_end", err, sc.exp_err);
      if (!aborted) begin
        chk("outputs_done", oidx, COLS);
        chk("last_wgt", last_wgt, COLS * ROWS - 1);
        chk("back_to_load", in_tready, 1);
      end
      if (sc.stall_len > 0) chk("stall_stable", stall_bad + ((stall_n != sc.stall_len) ? 1 : 0), 0);
      if (t == 0) chk("total_cycles", ((cyc_a + cyc) < 44100) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
